// File: rtl/alu_pkg.sv
// alu_pkg: shared select and mode codes for the ALU slice
package alu_pkg;
  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0110;
  localparam logic [3:0] S_OR = 4'b0001;
  localparam logic [3:0] S_AND = 4'b0100;
  localparam logic M_ARITH = 1'b1;
  localparam logic M_LOGIC = 1'b0;
endpackage

// File: rtl/alu_adder_slice_if.sv
// alu_adder_slice_if: operand, control and result bundle of the ALU slice
interface alu_adder_slice_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0] S;
  logic M;
  logic Pin;
  logic D;
  logic F;
  logic [WIDTH-1:0] R;
  logic Pout;
  modport master (output a, b, S, M, Pin, input D, F, R, Pout);
  modport slave (input a, b, S, M, Pin, output D, F, R, Pout);
endinterface

// File: rtl/alu_gp_cell.sv
// alu_gp_cell: per-bit select-controlled generate, propagate and half-sum
module alu_gp_cell (
  input  logic       a,
  input  logic       b,
  input  logic [3:0] S,
  output logic       G,
  output logic       P,
  output logic       H
);
  assign G = (a & b & S[3]) | (a & ~b & S[2]);
  assign P = a | (b & S[0]) | (~b & S[1]);
  assign H = P & ~G;
endmodule

// File: rtl/alu_adder_slice.sv
// alu_adder_slice: registered 74181-style ALU bit-slice with ripple carry and group G/P
module alu_adder_slice
  import alu_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic clk,
  input logic rst,
  alu_adder_slice_if.slave bus
);
  logic [WIDTH-1:0] g, p, h;
  logic [WIDTH:0] c;
  logic [WIDTH-1:0] r_d, r_q;
  logic d_d, d_q, f_d, f_q, pout_d, pout_q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    alu_gp_cell u_cell (
      .a(bus.a[i]),
      .b(bus.b[i]),
      .S(bus.S),
      .G(g[i]),
      .P(p[i]),
      .H(h[i])
    );
  end
  // carry chain (gated by mode), result, and group terms that ignore mode/carry-in
  always_comb begin
    c = '0;
    d_d = 1'b0;
    c[0] = (bus.M == M_ARITH) & bus.Pin;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = (bus.M == M_ARITH) & (g[i] | (p[i] & c[i]));
      d_d = g[i] | (p[i] & d_d);
    end
    r_d = h ^ c[WIDTH-1:0];
    pout_d = c[WIDTH];
    f_d = &p;
  end
  // output registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      d_q <= 1'b0;
      f_q <= 1'b0;
      pout_q <= 1'b0;
    end else begin
      r_q <= r_d;
      d_q <= d_d;
      f_q <= f_d;
      pout_q <= pout_d;
    end
  end
  assign bus.R = r_q;
  assign bus.D = d_q;
  assign bus.F = f_q;
  assign bus.Pout = pout_q;
endmodule

// File: tb/tb_alu_adder_slice.sv
// tb_alu_adder_slice: directed and random checks of 1-bit and 4-bit slices against an arithmetic model
module tb_alu_adder_slice;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] a_in = '0, b_in = '0, s_in = '0;
  logic m_in = 1'b0, pin_in = 1'b0;
  int cmp = 0, mis = 0;
  logic [6:0] e1, e4;
  alu_adder_slice_if #(.WIDTH(1)) if1 ();
  alu_adder_slice_if #(.WIDTH(4)) if4 ();
  assign if1.a = a_in[0];
  assign if1.b = b_in[0];
  assign if1.S = s_in;
  assign if1.M = m_in;
  assign if1.Pin = pin_in;
  assign if4.a = a_in;
  assign if4.b = b_in;
  assign if4.S = s_in;
  assign if4.M = m_in;
  assign if4.Pin = pin_in;
  alu_adder_slice #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  alu_adder_slice #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  always #5 clk = ~clk;
  // G is a subset of P, so the ripple chain is exactly the binary sum G + P + cin
  function automatic logic [6:0] ref_out(int w, logic [3:0] a, logic [3:0] b, logic [3:0] s, logic m, logic pin);
    int g = 0, p = 0, mask = (1 << w) - 1, sum;
    logic [3:0] r;
    logic co, d, f;
    for (int i = 0; i < w; i++) begin
      g |= int'((a[i] & b[i] & s[3]) | (a[i] & ~b[i] & s[2])) << i;
      p |= int'(a[i] | (b[i] & s[0]) | (~b[i] & s[1])) << i;
    end
    sum = g + p + ((m == M_ARITH) ? int'(pin) : 0);
    r = (m == M_ARITH) ? 4'(sum & mask) : 4'((g ^ p) & mask);
    co = (m == M_ARITH) && (((sum >> w) & 1) == 1);
    d = (((g + p) >> w) & 1) == 1;
    f = p == mask;
    return {d, f, co, r};
  endfunction
  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all(string tag, logic [6:0] x1, logic [6:0] x4);
    chk({tag, "_r1"}, {3'b0, if1.R}, {3'b0, x1[0]});
    chk({tag, "_pout1"}, {3'b0, if1.Pout}, {3'b0, x1[4]});
    chk({tag, "_f1"}, {3'b0, if1.F}, {3'b0, x1[5]});
    chk({tag, "_d1"}, {3'b0, if1.D}, {3'b0, x1[6]});
    chk({tag, "_r4"}, if4.R, x4[3:0]);
    chk({tag, "_pout4"}, {3'b0, if4.Pout}, {3'b0, x4[4]});
    chk({tag, "_f4"}, {3'b0, if4.F}, {3'b0, x4[5]});
    chk({tag, "_d4"}, {3'b0, if4.D}, {3'b0, x4[6]});
  endtask
  task automatic step(string tag, logic [3:0] a, logic [3:0] b, logic [3:0] s, logic m, logic pin);
    a_in = a;
    b_in = b;
    s_in = s;
    m_in = m;
    pin_in = pin;
    e1 = ref_out(1, a, b, s, m, pin);
    e4 = ref_out(4, a, b, s, m, pin);
    @(posedge clk);
    #1;
    check_all(tag, e1, e4);
  endtask
  initial begin
    #2;
    check_all("reset_init", 7'b0, 7'b0);
    @(negedge clk);
    rst = 1'b0;
    step("add_11_0", 4'h1, 4'h1, S_ADD, M_ARITH, 1'b0);
    chk("plan_add_r1", {3'b0, if1.R}, 4'h0);
    chk("plan_add_pout1", {3'b0, if1.Pout}, 4'h1);
    step("add_10_1", 4'h1, 4'h0, S_ADD, M_ARITH, 1'b1);
    step("sub_01_1", 4'h0, 4'h1, S_SUB, M_ARITH, 1'b1);
    chk("plan_sub_r1", {3'b0, if1.R}, 4'h1);
    chk("plan_sub_pout1", {3'b0, if1.Pout}, 4'h0);
    step("sub_10_0", 4'h1, 4'h0, S_SUB, M_ARITH, 1'b0);
    for (int i = 0; i < 4; i++) step("or_sweep", 4'(i >> 1), 4'(i & 1), S_OR, M_LOGIC, 1'b1);
    for (int i = 0; i < 4; i++) step("and_sweep", 4'(i >> 1), 4'(i & 1), S_AND, M_LOGIC, 1'b0);
    step("add4_f1", 4'hF, 4'h1, S_ADD, M_ARITH, 1'b0);
    chk("plan_add4_r", if4.R, 4'h0);
    chk("plan_add4_pout", {3'b0, if4.Pout}, 4'h1);
    step("add4_52", 4'h5, 4'h2, S_ADD, M_ARITH, 1'b1);
    chk("plan_add4b_r", if4.R, 4'h8);
    step("sub4_37", 4'h3, 4'h7, S_SUB, M_ARITH, 1'b1);
    chk("plan_sub4_r", if4.R, 4'hC);
    step("rst_load", 4'h1, 4'h1, S_ADD, M_ARITH, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all("rst_async", 7'b0, 7'b0);
    @(posedge clk);
    #1;
    check_all("rst_hold", 7'b0, 7'b0);
    #2;
    rst = 1'b0;
    step("rst_release", 4'hA, 4'h6, S_ADD, M_ARITH, 1'b1);
    for (int n = 0; n < 200; n++)
      step("rand", 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
